// File: rtl/noc_vc_requester_pkg.sv
// Shared types and field positions for the NoC virtual-channel requester.
// Contents:
//   flit_type_e : two-bit flit type carried in the top bits of every flit
//   state_e     : requester FSM state, also exposed for debug
//   TYPE_W      : width of the type field (it occupies [FLIT_W-1 -: TYPE_W])
//   DEST_LSB    : LSB of the destination field in a head flit
package noc_vc_pkg;

    typedef enum logic [1:0] {
        FT_HEAD_TAIL = 2'b00,
        FT_HEAD      = 2'b01,
        FT_BODY      = 2'b10,
        FT_TAIL      = 2'b11
    } flit_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b10,
        ST_DROP = 2'b11
    } state_e;

    localparam int TYPE_W   = 2;
    localparam int DEST_LSB = 0;

endpackage

// File: rtl/noc_vc_requester_if.sv
// Bundle of the requester's flit-in, arbiter and flit-out signals.
//
// Handshakes: a transfer on either flit channel happens in a cycle where
// valid and ready are both high at the rising clock edge. The sender holds
// its flit stable while valid is high and ready is low.
//
// Signals:
//   flit_i/valid_i/ready_o : upstream flit channel into the input buffer
//   req_o/grant_i          : one-hot request / grant vector with the arbiters
//   update_o               : one-cycle pulse, packet done, arbiter may rotate
//   flit_o/valid_o/ready_i : downstream flit channel (buffer head)
//   err_o                  : sticky protocol error flag
//   state_o                : current FSM state (debug visibility)
// Modports: master = the requester, slave = its environment.
interface noc_vc_requester_if
    import noc_vc_pkg::*;
#(
    parameter int N_OUT  = 2,
    parameter int FLIT_W = 34
);
    logic [FLIT_W-1:0] flit_i;
    logic              valid_i;
    logic              ready_o;
    logic [N_OUT-1:0]  req_o;
    logic [N_OUT-1:0]  grant_i;
    logic              update_o;
    logic [FLIT_W-1:0] flit_o;
    logic              valid_o;
    logic              ready_i;
    logic              err_o;
    state_e            state_o;

    modport master (
        input  flit_i, valid_i, grant_i, ready_i,
        output ready_o, req_o, update_o, flit_o, valid_o, err_o, state_o
    );

    modport slave (
        output flit_i, valid_i, grant_i, ready_i,
        input  ready_o, req_o, update_o, flit_o, valid_o, err_o, state_o
    );
endinterface

// File: rtl/noc_vc_requester_fifo.sv
// Synchronous flit FIFO, no bypass: a flit written in cycle t is visible at
// dout_o from t+1. Pointers carry one extra wrap bit to tell full from empty.
// Ports:
//   clk, arst        : clock, asynchronous active-low reset
//   push_i / din_i   : write request and data (ignored while full)
//   pop_i            : read request (ignored while empty)
//   dout_o           : current head entry (meaningless while empty)
//   full_o, empty_o  : occupancy flags
module flit_fifo #(
    parameter int FLIT_W     = 34,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [FLIT_W-1:0] din_i,
    output logic [FLIT_W-1:0] dout_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FLIT_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only observed when non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
endmodule

// File: rtl/noc_vc_requester.sv
// Requester side of the round-robin output arbitration protocol.
// Buffers incoming flits, decodes the head flit's destination into a one-hot
// request, holds it until granted, streams the packet head-to-tail and then
// pulses update_o so the arbiter can rotate. Misrouted or stray flits are
// discarded and flagged on the sticky err_o.
// Ports:
//   clk  : clock, rising edge
//   arst : asynchronous active-low reset
//   bus  : noc_vc_requester_if master modport (flit in/out, req/grant,
//          update, error, debug state)
// DEST_W must satisfy 2**DEST_W >= N_OUT; FIFO_DEPTH is a power of two >= 2.
module noc_vc_requester
    import noc_vc_pkg::*;
#(
    parameter int N_OUT      = 2,
    parameter int FLIT_W     = 34,
    parameter int DEST_W     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               arst,
    noc_vc_requester_if.master bus
);
    logic [FLIT_W-1:0] head;
    logic              full, empty, push, pop;
    flit_type_e        head_type;
    logic [DEST_W-1:0] head_dest;
    logic              is_head, is_last, dest_ok, granted, out_valid;
    logic [N_OUT-1:0]  route_dec;

    state_e            state_q, state_d;
    logic [N_OUT-1:0]  route_q, route_d;
    logic              update_q, update_d;
    logic              err_q, err_d;

    assign push = bus.valid_i & ~full;

    flit_fifo #(
        .FLIT_W    (FLIT_W),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .arst   (arst),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (bus.flit_i),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty)
    );

    assign head_type = flit_type_e'(head[FLIT_W-1 -: TYPE_W]);
    assign head_dest = head[DEST_LSB +: DEST_W];
    assign is_head   = (head_type == FT_HEAD) || (head_type == FT_HEAD_TAIL);
    assign is_last   = (head_type == FT_TAIL) || (head_type == FT_HEAD_TAIL);
    assign dest_ok   = (32'(head_dest) < 32'(N_OUT));
    // Only grant bits on our own route count; others belong to other inputs.
    assign granted   = |(bus.grant_i & route_q);

    always_comb begin
        route_dec = '0;
        for (int i = 0; i < N_OUT; i++) begin
            route_dec[i] = (head_dest == DEST_W'(i));
        end
    end

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        update_d  = 1'b0;
        err_d     = err_q;
        pop       = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (is_head && dest_ok) begin
                        route_d = route_dec;
                        state_d = ST_REQ;
                    end else if (is_head) begin
                        // Unroutable head: a single-flit packet is dropped on
                        // the spot, a multi-flit one is drained through DROP.
                        err_d = 1'b1;
                        if (head_type == FT_HEAD) state_d = ST_DROP;
                        else                      pop     = 1'b1;
                    end else begin
                        // BODY/TAIL with no packet open: discard it.
                        err_d = 1'b1;
                        pop   = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (granted) state_d = ST_XFER;
            end
            ST_XFER: begin
                // A withdrawn grant stalls the packet without leaving XFER.
                out_valid = ~empty & granted;
                if (out_valid && bus.ready_i) begin
                    pop = 1'b1;
                    if (is_last) begin
                        state_d  = ST_IDLE;
                        update_d = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_type == FT_TAIL) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q  <= ST_IDLE;
            route_q  <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            route_q  <= route_d;
            update_q <= update_d;
            err_q    <= err_d;
        end
    end

    assign bus.ready_o  = ~full;
    assign bus.req_o    = ((state_q == ST_REQ) || (state_q == ST_XFER)) ? route_q : '0;
    assign bus.valid_o  = out_valid;
    assign bus.flit_o   = head;
    assign bus.update_o = update_q;
    assign bus.err_o    = err_q;
    assign bus.state_o  = state_q;
endmodule

// File: tb/tb_noc_vc_requester.sv
module tb_noc_vc_requester;
    import noc_vc_pkg::*;

    localparam logic [1:0] T_HT = 2'b00;
    localparam logic [1:0] T_H  = 2'b01;
    localparam logic [1:0] T_B  = 2'b10;
    localparam logic [1:0] T_T  = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk  = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    noc_vc_requester_if #(.N_OUT(2), .FLIT_W(34)) b0 ();
    noc_vc_requester_if #(.N_OUT(1), .FLIT_W(34)) b1 ();

    noc_vc_requester #(.N_OUT(2), .FLIT_W(34), .DEST_W(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk (clk),
        .arst(arst),
        .bus (b0)
    );

    noc_vc_requester #(.N_OUT(1), .FLIT_W(34), .DEST_W(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk (clk),
        .arst(arst),
        .bus (b1)
    );

    // ---------------- bookkeeping ----------------
    int checks   = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] mk(input logic [1:0] t, input logic [31:0] p);
        return {t, p};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        bit          dut;
        logic        vi;
        logic [33:0] fi;
        logic [1:0]  gi;
        logic        ri;
        logic        e_ready;
        logic [1:0]  e_req;
        logic        e_valid;
        logic [33:0] e_flit;
        logic        e_upd;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input bit dut, input logic vi, input logic [33:0] fi,
                        input logic [1:0] gi, input logic ri,
                        input logic [1:0] e_req, input logic e_valid,
                        input logic [33:0] e_flit, input logic e_upd, input logic e_err);
        vec_t v;
        v.dut = dut; v.vi = vi; v.fi = fi; v.gi = gi; v.ri = ri;
        v.e_ready = 1'b1; v.e_req = e_req; v.e_valid = e_valid;
        v.e_flit = e_flit; v.e_upd = e_upd; v.e_err = e_err;
        vecs.push_back(v);
    endtask

    // ---------------- driver ----------------
    task automatic drive_idle();
        b0.valid_i = 1'b0; b0.flit_i = '0; b0.grant_i = '0; b0.ready_i = 1'b0;
        b1.valid_i = 1'b0; b1.flit_i = '0; b1.grant_i = '0; b1.ready_i = 1'b0;
    endtask

    task automatic apply_vec(input int idx, input vec_t v);
        logic        a_ready, a_valid, a_upd, a_err;
        logic [1:0]  a_req;
        logic [33:0] a_flit;
        @(negedge clk);
        drive_idle();
        if (v.dut == 1'b0) begin
            b0.valid_i = v.vi; b0.flit_i = v.fi; b0.grant_i = v.gi; b0.ready_i = v.ri;
        end else begin
            b1.valid_i = v.vi; b1.flit_i = v.fi; b1.grant_i = v.gi[0:0]; b1.ready_i = v.ri;
        end
        #4;
        if (v.dut == 1'b0) begin
            a_ready = b0.ready_o; a_req = b0.req_o; a_valid = b0.valid_o;
            a_flit = b0.flit_o; a_upd = b0.update_o; a_err = b0.err_o;
        end else begin
            a_ready = b1.ready_o; a_req = {1'b0, b1.req_o}; a_valid = b1.valid_o;
            a_flit = b1.flit_o; a_upd = b1.update_o; a_err = b1.err_o;
        end
        check($sformatf("v%0d_ready", idx), a_ready, v.e_ready);
        check($sformatf("v%0d_req", idx), a_req, v.e_req);
        check($sformatf("v%0d_valid", idx), a_valid, v.e_valid);
        if (v.e_valid) check($sformatf("v%0d_flit", idx), a_flit, v.e_flit);
        check($sformatf("v%0d_update", idx), a_upd, v.e_upd);
        check($sformatf("v%0d_err", idx), a_err, v.e_err);
    endtask

    // ---------------- test ----------------
    initial begin
        logic [33:0] a_h, a_b, a_t, b_ht, c_h, c_b1, c_b2, c_t, s_b, s_t, d_ht;
        logic [33:0] h1, bd1, t1, ht1;
        logic [33:0] bp [6];
        int idx, occ, seen_upd;
        bit push, pop;

        a_h  = mk(T_H, 32'hA1);  a_b  = mk(T_B, 32'hB0); a_t = mk(T_T, 32'hC0);
        b_ht = mk(T_HT, 32'hD0);
        c_h  = mk(T_H, 32'h10);  c_b1 = mk(T_B, 32'h11);
        c_b2 = mk(T_B, 32'h12);  c_t  = mk(T_T, 32'h13);
        s_b  = mk(T_B, 32'h20);  s_t  = mk(T_T, 32'h21); d_ht = mk(T_HT, 32'hE0);
        h1   = mk(T_H, 32'h51);  bd1  = mk(T_B, 32'h52);
        t1   = mk(T_T, 32'h53);  ht1  = mk(T_HT, 32'h60);

        // 3-flit packet to output 1, grant held
        addv(0, 1, a_h, 2'b10, 1, 2'b00, 0, '0,  0, 0);
        addv(0, 1, a_b, 2'b10, 1, 2'b00, 0, '0,  0, 0);
        addv(0, 1, a_t, 2'b10, 1, 2'b10, 0, '0,  0, 0);
        addv(0, 0, '0,  2'b10, 1, 2'b10, 1, a_h, 0, 0);
        addv(0, 0, '0,  2'b10, 1, 2'b10, 1, a_b, 0, 0);
        addv(0, 0, '0,  2'b10, 1, 2'b10, 1, a_t, 0, 0);
        addv(0, 0, '0,  2'b10, 1, 2'b00, 0, '0,  1, 0);
        addv(0, 0, '0,  2'b10, 1, 2'b00, 0, '0,  0, 0);
        // single-flit packet, grant delayed by 5 cycles
        addv(0, 1, b_ht, 2'b00, 1, 2'b00, 0, '0, 0, 0);
        addv(0, 0, '0,   2'b00, 1, 2'b00, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) addv(0, 0, '0, 2'b00, 1, 2'b01, 0, '0, 0, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b01, 0, '0,   0, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b01, 1, b_ht, 0, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b00, 0, '0,   1, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b00, 0, '0,   0, 0);
        // grant withdrawn for two cycles mid-packet
        addv(0, 1, c_h,  2'b01, 1, 2'b00, 0, '0,   0, 0);
        addv(0, 1, c_b1, 2'b01, 1, 2'b00, 0, '0,   0, 0);
        addv(0, 1, c_b2, 2'b01, 1, 2'b01, 0, '0,   0, 0);
        addv(0, 1, c_t,  2'b01, 1, 2'b01, 1, c_h,  0, 0);
        addv(0, 0, '0,   2'b00, 1, 2'b01, 0, '0,   0, 0);
        addv(0, 0, '0,   2'b00, 1, 2'b01, 0, '0,   0, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b01, 1, c_b1, 0, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b01, 1, c_b2, 0, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b01, 1, c_t,  0, 0);
        addv(0, 0, '0,   2'b01, 1, 2'b00, 0, '0,   1, 0);
        // stray BODY and TAIL, then a valid single-flit packet
        addv(0, 1, s_b,  2'b01, 1, 2'b00, 0, '0,   0, 0);
        addv(0, 1, s_t,  2'b01, 1, 2'b00, 0, '0,   0, 0);
        addv(0, 1, d_ht, 2'b01, 1, 2'b00, 0, '0,   0, 1);
        addv(0, 0, '0,   2'b01, 1, 2'b00, 0, '0,   0, 1);
        addv(0, 0, '0,   2'b01, 1, 2'b01, 0, '0,   0, 1);
        addv(0, 0, '0,   2'b01, 1, 2'b01, 1, d_ht, 0, 1);
        addv(0, 0, '0,   2'b01, 1, 2'b00, 0, '0,   1, 1);
        addv(0, 0, '0,   2'b01, 1, 2'b00, 0, '0,   0, 1);
        // N_OUT=1 instance: dest=1 packet dropped, then a valid packet
        addv(1, 1, h1,  2'b01, 1, 2'b00, 0, '0,  0, 0);
        addv(1, 1, bd1, 2'b01, 1, 2'b00, 0, '0,  0, 0);
        addv(1, 1, t1,  2'b01, 1, 2'b00, 0, '0,  0, 1);
        addv(1, 1, ht1, 2'b01, 1, 2'b00, 0, '0,  0, 1);
        addv(1, 0, '0,  2'b01, 1, 2'b00, 0, '0,  0, 1);
        addv(1, 0, '0,  2'b01, 1, 2'b00, 0, '0,  0, 1);
        addv(1, 0, '0,  2'b01, 1, 2'b01, 0, '0,  0, 1);
        addv(1, 0, '0,  2'b01, 1, 2'b01, 1, ht1, 0, 1);
        addv(1, 0, '0,  2'b01, 1, 2'b00, 0, '0,  1, 1);
        addv(1, 0, '0,  2'b01, 1, 2'b00, 0, '0,  0, 1);

        // reset
        drive_idle();
        arst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", b0.req_o, 2'b00);
        check("rst_valid", b0.valid_o, 1'b0);
        check("rst_update", b0.update_o, 1'b0);
        check("rst_err", b0.err_o, 1'b0);
        check("rst_ready", b0.ready_o, 1'b1);
        check("rst1_req", b1.req_o, 1'b0);
        @(negedge clk);
        arst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply_vec(i, vecs[i]);

        // backpressure: 6 flits into a 4-deep buffer with ready_i low
        bp[0] = mk(T_H, 32'h30);
        for (int i = 1; i < 5; i++) bp[i] = mk(T_B, 32'h30 + i);
        bp[5] = mk(T_T, 32'h35);
        idx = 0; occ = 0; seen_upd = 0;
        exp_q.delete();
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            drive_idle();
            b0.grant_i = 2'b01;
            b0.ready_i = (cyc >= 10);
            if (idx < 6) begin
                b0.valid_i = 1'b1;
                b0.flit_i  = bp[idx];
            end
            #4;
            check($sformatf("bp%0d_ready", cyc), b0.ready_o, (occ != 4));
            if (cyc == 9) check("bp_accepted_before_drain", 64'(idx), 64'd4);
            if (b0.update_o) seen_upd++;
            push = b0.valid_i && b0.ready_o;
            pop  = b0.valid_o && b0.ready_i;
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("bp%0d_unexpected_flit", cyc), b0.flit_o, '0);
                end else begin
                    check($sformatf("bp%0d_flit", cyc), b0.flit_o, exp_q.pop_front());
                end
            end
            if (push) begin
                exp_q.push_back(bp[idx]);
                idx++;
            end
            occ = occ + int'(push) - int'(pop);
        end
        check("bp_all_accepted", 64'(idx), 64'd6);
        check("bp_all_delivered", 64'(exp_q.size()), 64'd0);
        check("bp_update_count", 64'(seen_upd), 64'd1);
        check("bp_err_sticky", b0.err_o, 1'b1);

        // reset in the middle of a 3-flit transfer
        @(negedge clk);
        drive_idle();
        b0.valid_i = 1'b1; b0.flit_i = mk(T_H, 32'h41); b0.grant_i = 2'b10;
        @(negedge clk);
        b0.flit_i = mk(T_B, 32'h42);
        @(negedge clk);
        b0.flit_i = mk(T_T, 32'h43);
        @(negedge clk);
        b0.valid_i = 1'b0;
        #4;
        check("mid_valid_before_reset", b0.valid_o, 1'b1);
        check("mid_req_before_reset", b0.req_o, 2'b10);
        @(negedge clk);
        arst = 1'b0;
        #1;
        check("mid_rst_req", b0.req_o, 2'b00);
        check("mid_rst_valid", b0.valid_o, 1'b0);
        check("mid_rst_ready", b0.ready_o, 1'b1);
        check("mid_rst_err", b0.err_o, 1'b0);
        @(negedge clk);
        arst = 1'b1;
        b0.ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #4;
            check($sformatf("post_rst%0d_valid", i), b0.valid_o, 1'b0);
            check($sformatf("post_rst%0d_update", i), b0.update_o, 1'b0);
            check($sformatf("post_rst%0d_req", i), b0.req_o, 2'b00);
            check($sformatf("post_rst%0d_ready", i), b0.ready_o, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
